// File: rtl/mac_result_drain.sv
// -----------------------------------------------------------------------------
// mac_result_drain
//   Snapshots the N accumulators of a MAC row on a capture strobe and streams
//   the results out one lane per transfer (lane 0 first) over valid/ready. Each
//   result is logically right-shifted by SHIFT and saturated to OUT_W bits.
//   Because the snapshot is held locally, the MAC row can be cleared and reused
//   while the results drain.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   capture    single-cycle strobe, snapshot acc_in
//   acc_in     packed accumulators, lane i = acc_in[i*ACC_W +: ACC_W]
//   out_data   scaled/saturated result of the current lane
//   out_idx    lane index of out_data
//   out_valid  out_data/out_idx/out_last valid
//   out_ready  downstream accepts when high together with out_valid
//   out_last   high with out_valid on lane N-1
//   busy       snapshot held, drain in progress
//   done       one-cycle pulse after the final lane transfers
//   overrun    sticky, a capture arrived while busy
// -----------------------------------------------------------------------------
module mac_result_drain #(
    parameter int N     = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture,
    input  logic [N*ACC_W-1:0]     acc_in,
    output logic [OUT_W-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   snap_q [N];
    logic [ACC_W-1:0]   snap_d [N];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;

    // Treat the accumulator as unsigned, shift logically, then clamp to the
    // largest OUT_W value. The one-bit zero extension keeps the comparison
    // well-formed even when OUT_W == ACC_W (no saturation possible).
    function automatic logic [OUT_W-1:0] scale_sat(input logic [ACC_W-1:0] x);
        logic [ACC_W-1:0] v;
        v = x >> SHIFT;
        if ({1'b0, v} > {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}})
            return '1;
        else
            return v[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        for (int i = 0; i < N; i++) snap_d[i] = snap_q[i];

        case (state_q)
            IDLE: begin
                if (capture) begin
                    for (int i = 0; i < N; i++) snap_d[i] = acc_in[i*ACC_W +: ACC_W];
                    idx_d   = '0;
                    // Lane 0 result comes straight from the value being latched,
                    // so it is valid one cycle after capture.
                    data_d  = scale_sat(acc_in[0 +: ACC_W]);
                    state_d = SEND;
                end
            end
            SEND: begin
                // Capture while busy (including on the final-transfer edge) is
                // dropped; only the sticky flag records it.
                if (capture) ovr_d = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = scale_sat(snap_q[idx_q + IDX_W'(1)]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < N; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < N; i++) snap_q[i] <= snap_d[i];
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    assign done      = done_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

    logic         clk;
    logic         reset;
    logic         capture;
    logic [127:0] acc_in;
    logic         out_ready;

    logic [15:0]  d0_data,  d8_data;
    logic [1:0]   d0_idx,   d8_idx;
    logic         d0_valid, d8_valid;
    logic         d0_last,  d8_last;
    logic         d0_busy,  d8_busy;
    logic         d0_done,  d8_done;
    logic         d0_ovr,   d8_ovr;

    int n_cmp = 0;
    int n_err = 0;

    mac_result_drain #(.N(4), .ACC_W(32), .OUT_W(16), .SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .capture(capture), .acc_in(acc_in),
        .out_data(d0_data), .out_idx(d0_idx), .out_valid(d0_valid),
        .out_ready(out_ready), .out_last(d0_last), .busy(d0_busy),
        .done(d0_done), .overrun(d0_ovr)
    );

    mac_result_drain #(.N(4), .ACC_W(32), .OUT_W(16), .SHIFT(8)) dut8 (
        .clk(clk), .reset(reset), .capture(capture), .acc_in(acc_in),
        .out_data(d8_data), .out_idx(d8_idx), .out_valid(d8_valid),
        .out_ready(out_ready), .out_last(d8_last), .busy(d8_busy),
        .done(d8_done), .overrun(d8_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [3:0][31:0] acc;
        logic [3:0][15:0] e0;   // expected with SHIFT=0
        logic [3:0][15:0] e8;   // expected with SHIFT=8
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture v, drain with out_ready held high, check every lane on both DUTs.
    task automatic run_drain(input vec_t v, input string tag);
        acc_in    = v.acc;
        capture   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        acc_in  = ~v.acc;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), {31'd0, d0_valid}, 32'd1);
            chk($sformatf("%s_idx%0d",   tag, i), {30'd0, d0_idx}, i);
            chk($sformatf("%s_data%0d",  tag, i), {16'd0, d0_data}, {16'd0, v.e0[i]});
            chk($sformatf("%s_data8_%0d", tag, i), {16'd0, d8_data}, {16'd0, v.e8[i]});
            chk($sformatf("%s_last%0d",  tag, i), {31'd0, d0_last}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s_busy%0d",  tag, i), {31'd0, d0_busy}, 32'd1);
            chk($sformatf("%s_done%0d",  tag, i), {31'd0, d0_done}, 32'd0);
            @(posedge clk); #1;
        end
        chk({tag, "_end_valid"}, {31'd0, d0_valid}, 32'd0);
        chk({tag, "_end_busy"},  {31'd0, d0_busy},  32'd0);
        chk({tag, "_end_done"},  {31'd0, d0_done},  32'd1);
        chk({tag, "_end_idx"},   {30'd0, d0_idx},   32'd0);
        chk({tag, "_end_last"},  {31'd0, d0_last},  32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_clr"},  {31'd0, d0_done},  32'd0);
    endtask

    initial begin
        logic [6:0]  rdy_pat;
        logic [3:0][15:0] exp_bp;
        int          e_idx;
        int          n_done;

        // lanes listed {lane3, lane2, lane1, lane0}
        vecs[0].acc = {32'd40, 32'd20 + 32'd10, 32'd20, 32'd10};
        vecs[0].e0  = {16'd40, 16'd30, 16'd20, 16'd10};
        vecs[0].e8  = {16'd0,  16'd0,  16'd0,  16'd0};
        vecs[1].acc = {32'h0000_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF};
        vecs[1].e0  = {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vecs[1].e8  = {16'h0000, 16'hFFFF, 16'h0100, 16'h00FF};
        vecs[2].acc = {32'h0100_0000, 32'h0000_00FF, 32'h00FF_FF00, 32'h0001_2345};
        vecs[2].e0  = {16'hFFFF, 16'h00FF, 16'hFFFF, 16'hFFFF};
        vecs[2].e8  = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0123};

        reset = 1'b0; capture = 1'b0; acc_in = '0; out_ready = 1'b0;
        #1;
        chk("rst_valid", {31'd0, d0_valid}, 32'd0);
        chk("rst_busy",  {31'd0, d0_busy},  32'd0);
        chk("rst_done",  {31'd0, d0_done},  32'd0);
        chk("rst_ovr",   {31'd0, d0_ovr},   32'd0);
        chk("rst_data",  {16'd0, d0_data},  32'd0);
        chk("rst_idx",   {30'd0, d0_idx},   32'd0);
        chk("rst_last",  {31'd0, d0_last},  32'd0);
        #11 reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_valid", {31'd0, d0_valid}, 32'd0);

        for (int k = 0; k < 3; k++) run_drain(vecs[k], $sformatf("vec%0d", k));

        // Backpressure: ready pattern per cycle after capture = 0,0,1,0,1,1,1
        rdy_pat = 7'b1110100;
        exp_bp  = vecs[0].e0;
        acc_in = vecs[0].acc; capture = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        capture = 1'b0;
        acc_in  = {32'd7, 32'd7, 32'd7, 32'd7};
        e_idx = 0; n_done = 0;
        for (int c = 0; c < 7; c++) begin
            out_ready = rdy_pat[c];
            chk($sformatf("bp_valid%0d", c), {31'd0, d0_valid}, 32'd1);
            chk($sformatf("bp_idx%0d", c),   {30'd0, d0_idx}, e_idx);
            chk($sformatf("bp_data%0d", c),  {16'd0, d0_data}, {16'd0, exp_bp[e_idx]});
            @(posedge clk); #1;
            if (d0_done) n_done++;
            if (rdy_pat[c]) e_idx++;
        end
        out_ready = 1'b0;
        chk("bp_xfers", e_idx, 4);
        chk("bp_valid_end", {31'd0, d0_valid}, 32'd0);
        @(posedge clk); #1;
        if (d0_done) n_done++;
        chk("bp_done_once", n_done, 1);
        chk("bp_ovr", {31'd0, d0_ovr}, 32'd0);

        // Overrun: captures during lane 1 and on the final-transfer edge
        acc_in = {32'd4, 32'd3, 32'd2, 32'd1}; capture = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        chk("ov_l0", {16'd0, d0_data}, 32'd1);
        @(posedge clk); #1;
        chk("ov_l1", {16'd0, d0_data}, 32'd2);
        chk("ov_pre", {31'd0, d0_ovr}, 32'd0);
        acc_in = {4{32'd99}}; capture = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        chk("ov_l2", {16'd0, d0_data}, 32'd3);
        chk("ov_l2_idx", {30'd0, d0_idx}, 32'd2);
        chk("ov_set", {31'd0, d0_ovr}, 32'd1);
        @(posedge clk); #1;
        chk("ov_l3", {16'd0, d0_data}, 32'd4);
        chk("ov_l3_last", {31'd0, d0_last}, 32'd1);
        capture = 1'b1;
        @(posedge clk); #1;
        chk("ov_done", {31'd0, d0_done}, 32'd1);
        chk("ov_no_drain", {31'd0, d0_valid}, 32'd0);
        chk("ov_sticky", {31'd0, d0_ovr}, 32'd1);
        // capture held high into the done cycle starts a new drain
        acc_in = {32'd8, 32'd7, 32'd6, 32'd5};
        @(posedge clk); #1;
        capture = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ov_new_valid%0d", i), {31'd0, d0_valid}, 32'd1);
            chk($sformatf("ov_new_data%0d", i), {16'd0, d0_data}, 5 + i);
            @(posedge clk); #1;
        end
        chk("ov_new_done", {31'd0, d0_done}, 32'd1);
        chk("ov_still", {31'd0, d0_ovr}, 32'd1);

        // Reset mid-drain, asserted between edges
        @(posedge clk); #1;
        acc_in = vecs[1].acc; capture = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        capture = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rm_l2_idx", {30'd0, d0_idx}, 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("rm_valid", {31'd0, d0_valid}, 32'd0);
        chk("rm_busy",  {31'd0, d0_busy},  32'd0);
        chk("rm_ovr",   {31'd0, d0_ovr},   32'd0);
        chk("rm_data",  {16'd0, d0_data},  32'd0);
        chk("rm_idx",   {30'd0, d0_idx},   32'd0);
        @(posedge clk); #1;
        chk("rm_done_hold", {31'd0, d0_done}, 32'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("rm_done_after", {31'd0, d0_done}, 32'd0);
        chk("rm_valid_after", {31'd0, d0_valid}, 32'd0);
        run_drain(vecs[2], "post_rst");
        chk("post_rst_ovr", {31'd0, d0_ovr}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
